// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, flag layout and skid-buffer states for the ALU result stage.
package alu_pkg;
  typedef enum logic [4:0] {
    MOV = 5'd0, CMP = 5'd1, ADD = 5'd2, SUB = 5'd3, MUL = 5'd4, DIV = 5'd5,
    XOR = 5'd6, AND = 5'd7, NOT = 5'd8, SHL = 5'd9, SHR = 5'd10
  } alu_op_e;
  localparam logic [4:0] ALU_OP_MAX = 5'd10;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational N/Z/C/V flags and illegal-op detection for one ALU result.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [4:0] select,
  input  logic [N:0] result,
  input  logic       carry,
  input  logic       overflow,
  output flags_t     flags,
  output logic       illegal
);
  logic arith;
  always_comb begin
    arith   = select inside {CMP, ADD, SUB};
    flags   = '{n: result[N], z: result == '0, c: arith & carry, v: arith & overflow};
    illegal = select > ALU_OP_MAX;
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered ALU output stage with 2-entry skid buffer and flag capture.
// Optional ALU_STICKY_FLAGS_EN adds a sticky overflow bit set on fire of a V=1 entry.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_select,
  input  logic [N:0]       in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:0]       out_result,
  output logic [4:0]       out_select,
  output logic [3:0]       out_flags,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count,
  input  logic             clr_sticky,
  output logic             sticky_v
);
  localparam int E = N + 11;
  flags_t          fg_flags;
  logic            fg_illegal;
  logic [E-1:0]    in_ent, m_q, m_d, s_q, s_d;
  skid_state_e     state_q, state_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic            acc, fire;

  alu_flag_gen #(.N(N)) u_flag_gen (
    .select   (in_select),
    .result   (in_result),
    .carry    (in_carry),
    .overflow (in_overflow),
    .flags    (fg_flags),
    .illegal  (fg_illegal)
  );

  // Entry layout: {illegal, flags, select, result}
  assign in_ent      = {fg_illegal, fg_flags, in_select, in_result};
  assign in_ready    = state_q != TWO;
  assign out_valid   = state_q != EMPTY;
  assign out_result  = m_q[N:0];
  assign out_select  = m_q[N+5:N+1];
  assign out_flags   = m_q[N+9:N+6];
  assign out_illegal = m_q[N+10];
  assign op_count    = op_count_q;

  always_comb begin
    acc        = in_valid & in_ready;
    fire       = out_valid & out_ready;
    state_d    = state_q;
    m_d        = m_q;
    s_d        = s_q;
    op_count_d = acc ? op_count_q + 1'b1 : op_count_q;
    case (state_q)
      EMPTY: begin
        state_d = acc ? ONE : EMPTY;
        m_d     = acc ? in_ent : m_q;
      end
      ONE: begin
        state_d = acc ? (fire ? ONE : TWO) : (fire ? EMPTY : ONE);
        m_d     = acc & fire ? in_ent : m_q;
        s_d     = acc & !fire ? in_ent : s_q;
      end
      TWO: begin
        state_d = fire ? ONE : TWO;
        m_d     = fire ? s_q : m_q;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      op_count_q <= op_count_d;
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_q, sticky_d;
  // A set on fire overrides a same-cycle clear
  always_comb sticky_d = (sticky_q & ~clr_sticky) | (fire & m_q[N+6]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end
  assign sticky_v = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = clr_sticky;
  assign sticky_v   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_carry = 1'b0, in_overflow = 1'b0;
  logic [4:0]  in_select = '0, out_select;
  logic [4:0]  in_result = '0, out_result;
  logic        out_valid, out_ready = 1'b0, out_illegal, clr_sticky = 1'b0, sticky_v;
  logic [3:0]  out_flags;
  logic [15:0] op_count;
  int          checks = 0, errors = 0;
  logic        sv_exp;

  alu_result_stage #(.N(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_select(in_select), .in_result(in_result), .in_carry(in_carry),
    .in_overflow(in_overflow), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_select(out_select), .out_flags(out_flags),
    .out_illegal(out_illegal), .op_count(op_count), .clr_sticky(clr_sticky),
    .sticky_v(sticky_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] sel, input logic [4:0] res,
                       input logic c, input logic o);
    in_valid = v; in_select = sel; in_result = res; in_carry = c; in_overflow = o;
  endtask

  initial begin
`ifdef ALU_STICKY_FLAGS_EN
    sv_exp = 1'b1;
`else
    sv_exp = 1'b0;
`endif
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_select", out_select, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_sticky", sticky_v, 0);
    step();
    rst = 1'b0;
    // Test 1: add with zero result and carry
    out_ready = 1'b1;
    drive(1, 5'd2, 5'h00, 1, 0);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_result", out_result, 0);
    chk("t1_flags", out_flags, 4'b0110);
    chk("t1_count", op_count, 1);
    drive(0, 5'd0, 5'h00, 0, 0);
    step();
    chk("t1_drain", out_valid, 0);
    // Test 2: back-pressure fills the skid buffer
    out_ready = 1'b0;
    drive(1, 5'd0, 5'd1, 0, 0);
    step();
    chk("t2_first", out_result, 1);
    drive(1, 5'd0, 5'd2, 0, 0);
    step();
    chk("t2_full_ready", in_ready, 0);
    chk("t2_full_result", out_result, 1);
    chk("t2_full_count", op_count, 3);
    drive(1, 5'd0, 5'd3, 0, 0);
    step();
    chk("t2_ignored_count", op_count, 3);
    chk("t2_hold_result", out_result, 1);
    chk("t2_hold_ready", in_ready, 0);
    drive(0, 5'd0, 5'd3, 0, 0);
    out_ready = 1'b1;
    step();
    chk("t2_second", out_result, 2);
    chk("t2_second_valid", out_valid, 1);
    chk("t2_reopen", in_ready, 1);
    drive(1, 5'd0, 5'd3, 0, 0);
    step();
    chk("t2_third", out_result, 3);
    chk("t2_third_count", op_count, 4);
    drive(0, 5'd0, 5'd0, 0, 0);
    step();
    chk("t2_drain", out_valid, 0);
    // Test 3: XOR masks carry/overflow
    drive(1, 5'd6, 5'h10, 1, 1);
    step();
    chk("t3_flags", out_flags, 4'b1000);
    chk("t3_illegal", out_illegal, 0);
    // Test 4: illegal op 12, then boundary op 10
    drive(1, 5'd12, 5'h00, 1, 1);
    step();
    chk("t4_illegal", out_illegal, 1);
    chk("t4_flags", out_flags, 4'b0100);
    chk("t4_select", out_select, 12);
    drive(1, 5'd10, 5'h1F, 1, 1);
    step();
    chk("t4_op10_illegal", out_illegal, 0);
    chk("t4_op10_flags", out_flags, 4'b1000);
    drive(1, 5'd1, 5'h1F, 1, 1);
    step();
    chk("t4_cmp_flags", out_flags, 4'b1011);
    drive(0, 5'd0, 5'd0, 0, 0);
    step();
    chk("t4_drain", out_valid, 0);
    // Test 6: sticky overflow
    drive(1, 5'd3, 5'd1, 0, 1);
    step();
    chk("t6_sub_flags", out_flags, 4'b0001);
    chk("t6_pre_sticky", sticky_v, 0);
    drive(1, 5'd3, 5'd2, 0, 1);
    step();
    chk("t6_set", sticky_v, sv_exp);
    drive(0, 5'd0, 5'd0, 0, 0);
    clr_sticky = 1'b1;
    step();
    chk("t6_set_wins", sticky_v, sv_exp);
    chk("t6_empty", out_valid, 0);
    step();
    chk("t6_cleared", sticky_v, 0);
    clr_sticky = 1'b0;
    chk("t6_count", op_count, 10);
    // Test 5: async reset while two entries are buffered
    out_ready = 1'b0;
    drive(1, 5'd0, 5'd7, 0, 0);
    step();
    step();
    drive(0, 5'd0, 5'd0, 0, 0);
    chk("t5_two", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_ready", in_ready, 1);
    chk("t5_count", op_count, 0);
    chk("t5_result", out_result, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t5_stays_empty", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
